// File: rtl/uart_line_arbiter.sv
// uart_line_arbiter: round-robin owner of a shared serial byte channel, holding each grant until newline, byte limit or idle timeout
module uart_line_arbiter #(
   parameter int NREQ = 4,
   parameter int MAX_HOLD = 64,
   parameter int IDLE_TIMEOUT = 16,
   localparam int IW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_bits,
   output logic [NREQ-1:0]   req_ready,
   output logic              serial_out_valid,
   input  logic              serial_out_ready,
   output logic [7:0]        serial_out_bits,
   output logic              grant_active,
   output logic [IW-1:0]     grant_id
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t          state, state_nx;
   logic [IW-1:0]   grant_nx, rr_ptr, rr_nx, pick;
   logic [7:0]      byte_cnt, byte_nx, idle_cnt, idle_nx;
   logic            cur_valid, xfer, rel;
   // first requesting index at or above rr_ptr, wrapping; scanned backwards so the nearest wins
   always_comb begin
      pick = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (req_valid[(int'(rr_ptr) + k) % NREQ]) pick = IW'((int'(rr_ptr) + k) % NREQ);
   end
   // zero-latency pass-through of the owning requester onto the shared channel
   always_comb begin
      grant_active = (state == GRANT);
      cur_valid = req_valid[grant_id];
      serial_out_valid = grant_active & cur_valid;
      serial_out_bits = grant_active ? req_bits[8*grant_id +: 8] : 8'h00;
      req_ready = '0;
      req_ready[grant_id] = grant_active & serial_out_ready;
      xfer = serial_out_valid & serial_out_ready;
   end
   // grant/release decisions; all release causes fold into a single release
   always_comb begin
      state_nx = state;
      grant_nx = grant_id;
      rr_nx = rr_ptr;
      byte_nx = byte_cnt;
      idle_nx = idle_cnt;
      rel = 1'b0;
      if (state == IDLE) begin
         if (|req_valid) begin
            state_nx = GRANT;
            grant_nx = pick;
            byte_nx = '0;
            idle_nx = '0;
         end
      end else begin
         rel = (xfer && (serial_out_bits == 8'h0A || byte_cnt + 8'd1 == 8'(MAX_HOLD)))
            || (!cur_valid && idle_cnt + 8'd1 == 8'(IDLE_TIMEOUT));
         byte_nx = byte_cnt + {7'd0, xfer};
         idle_nx = cur_valid ? 8'd0 : idle_cnt + 8'd1;
         if (rel) begin
            state_nx = IDLE;
            grant_nx = '0;
            rr_nx = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            byte_nx = '0;
            idle_nx = '0;
         end
      end
   end
   // state and counter registers; reset abandons any grant at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant_id <= '0;
         rr_ptr <= '0;
         byte_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         state <= state_nx;
         grant_id <= grant_nx;
         rr_ptr <= rr_nx;
         byte_cnt <= byte_nx;
         idle_cnt <= idle_nx;
      end
   end
endmodule

// File: tb/tb_uart_line_arbiter.sv
// tb_uart_line_arbiter: directed scenarios with a byte scoreboard checked by an independent monitor
module tb_uart_line_arbiter;
   localparam int NREQ = 4, MAX_HOLD = 8, IDLE_TIMEOUT = 4;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_bits;
   logic [NREQ-1:0]   req_ready;
   logic              serial_out_valid;
   logic              serial_out_ready = 1'b1;
   logic [7:0]        serial_out_bits;
   logic              grant_active;
   logic [1:0]        grant_id;
   int vectors = 0, miscompares = 0;
   logic [7:0] mem [NREQ][64];
   int head [NREQ] = '{default: 0};
   int tail [NREQ] = '{default: 0};
   logic [9:0] exp_q [$];
   logic [9:0] e;
   logic [NREQ-1:0] xf;

   uart_line_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bits(req_bits), .req_ready(req_ready),
      .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
      .serial_out_bits(serial_out_bits), .grant_active(grant_active), .grant_id(grant_id));

   always #5 clk = ~clk;

   task automatic check(string name, int act, int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(int i, logic [7:0] b);
      mem[i][tail[i]] = b;
      tail[i]++;
   endtask

   task automatic expect_b(logic [1:0] g, logic [7:0] b);
      exp_q.push_back({g, b});
   endtask

   task automatic drain(string name);
      int n = 0;
      bit busy = 1'b1;
      while (busy && n < 300) begin
         cyc(1);
         n++;
         busy = exp_q.size() != 0;
         for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) busy = 1'b1;
      end
      check({name, "_drained"}, exp_q.size(), 0);
      cyc(IDLE_TIMEOUT + 3);
      check({name, "_settled"}, grant_active, 0);
   endtask

   // requester models: present queued bytes, advance on accepted transfers
   initial begin
      req_valid = '0;
      req_bits = '0;
      forever begin
         @(negedge clk);
         xf = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) if (xf[i] && rst_n) head[i]++;
         #1;
         for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = head[i] < tail[i];
            if (head[i] < tail[i]) req_bits[8*i +: 8] = mem[i][head[i]];
         end
      end
   end

   // monitor: every byte taken by the channel must be the next expected {grant_id, byte}
   initial forever begin
      @(negedge clk);
      if (serial_out_valid && serial_out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_byte: got id %0d byte %02h, expected none", grant_id, serial_out_bits);
         end else begin
            e = exp_q.pop_front();
            if ({grant_id, serial_out_bits} !== e) begin
               miscompares++;
               $display("FAIL byte: got id %0d byte %02h, expected id %0d byte %02h",
                        grant_id, serial_out_bits, e[9:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      cyc(3);
      check("rst_grant_active", grant_active, 0);
      check("rst_valid", serial_out_valid, 0);
      check("rst_ready", req_ready, 0);
      check("rst_bits", serial_out_bits, 0);
      check("rst_grant_id", grant_id, 0);
      rst_n = 1'b1;
      cyc(2);
      // "hi\n" from requester 2
      load(2, 8'h68); load(2, 8'h69); load(2, 8'h0A);
      expect_b(2, 8'h68); expect_b(2, 8'h69); expect_b(2, 8'h0A);
      cyc(1);
      check("t1_grant_c1", grant_active, 1);
      check("t1_id_c1", grant_id, 2);
      cyc(2);
      check("t1_grant_c3", grant_active, 1);
      cyc(1);
      check("t1_idle_c4", grant_active, 0);
      drain("t1");
      // rr_ptr is 3: requester 3 wins over 2
      load(3, 8'h0A); load(2, 8'h0A);
      expect_b(3, 8'h0A); expect_b(2, 8'h0A);
      drain("t1b");
      rst_n = 1'b0;
      #1;
      check("pulse_rst_grant", grant_active, 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      // all four send "a\n", requester 0 twice: order 0,1,2,3,0
      for (int i = 0; i < NREQ; i++) begin
         load(i, 8'h61); load(i, 8'h0A);
         expect_b(2'(i), 8'h61); expect_b(2'(i), 8'h0A);
      end
      load(0, 8'h61); load(0, 8'h0A);
      expect_b(0, 8'h61); expect_b(0, 8'h0A);
      cyc(3);
      check("t2_bubble_c3", grant_active, 0);
      cyc(1);
      check("t2_id_c4", grant_id, 1);
      cyc(8);
      check("t2_bubble_c12", grant_active, 0);
      cyc(1);
      check("t2_grant_c13", grant_active, 1);
      check("t2_id_c13", grant_id, 0);
      drain("t2");
      // requester 1 streams 20 bytes, held to 8 per grant; requester 3 interleaves
      for (int k = 0; k < 20; k++) load(1, 8'(8'h30 + k));
      load(3, 8'h33); load(3, 8'h0A);
      for (int k = 0; k < 8; k++) expect_b(1, 8'(8'h30 + k));
      expect_b(3, 8'h33); expect_b(3, 8'h0A);
      for (int k = 8; k < 20; k++) expect_b(1, 8'(8'h30 + k));
      drain("t3");
      // requester 0 sends one byte then goes quiet; timeout hands over to 2
      load(0, 8'h55);
      expect_b(0, 8'h55);
      cyc(1);
      check("t4_id_c1", grant_id, 0);
      cyc(1);
      load(2, 8'h0A);
      expect_b(2, 8'h0A);
      cyc(3);
      check("t4_hold_c5", grant_active, 1);
      cyc(1);
      check("t4_release_c6", grant_active, 0);
      cyc(1);
      check("t4_grant_c7", grant_active, 1);
      check("t4_id_c7", grant_id, 2);
      drain("t4");
      // backpressure longer than the idle timeout must not release
      serial_out_ready = 1'b0;
      load(0, 8'h0A);
      expect_b(0, 8'h0A);
      cyc(11);
      check("t5_hold", grant_active, 1);
      check("t5_valid", serial_out_valid, 1);
      check("t5_ready", req_ready, 0);
      serial_out_ready = 1'b1;
      cyc(1);
      check("t5_released", grant_active, 0);
      drain("t5");
      // reset during a stalled grant
      serial_out_ready = 1'b0;
      load(1, 8'h41);
      cyc(2);
      check("t6_grant", grant_active, 1);
      check("t6_id", grant_id, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", serial_out_valid, 0);
      check("t6_rst_grant", grant_active, 0);
      check("t6_rst_ready", req_ready, 0);
      check("t6_rst_bits", serial_out_bits, 0);
      check("t6_rst_id", grant_id, 0);
      for (int i = 0; i < NREQ; i++) head[i] = tail[i];
      cyc(2);
      rst_n = 1'b1;
      serial_out_ready = 1'b1;
      load(0, 8'h0A); load(2, 8'h0A);
      expect_b(0, 8'h0A); expect_b(2, 8'h0A);
      drain("t6a");
      load(3, 8'h0A);
      expect_b(3, 8'h0A);
      cyc(1);
      check("t6_id3", grant_id, 3);
      drain("t6b");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_line_arbiter.md
UART_LINE_ARBITER -- requirements
Module: uart_line_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte-stream requesters sharing one serial output channel (2..16).
REQ-002 Parameter MAX_HOLD, default 64, maximum bytes accepted per grant before forced release (1..255).
REQ-003 Parameter IDLE_TIMEOUT, default 16, consecutive cycles the granted requester may hold req_valid low before forced release (1..255).
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset; state clears while reset=0.
REQ-006 req_valid  input  NREQ  bit i: requester i presents a byte.
REQ-007 req_bits  input  8*NREQ  byte of requester i in bits [8i+7:8i].
REQ-008 req_ready  output  NREQ  bit i: requester i's byte accepted this cycle when req_valid[i]=1.
REQ-009 serial_out_valid  output  1  byte presented to the shared UART channel.
REQ-010 serial_out_ready  input  1  shared channel accepts the byte.
REQ-011 serial_out_bits  output  8  byte to the shared channel.
REQ-012 grant_active  output  1  a requester currently owns the channel.
REQ-013 grant_id  output  clog2(NREQ)  index of the owning requester; 0 when grant_active=0.

Function
REQ-014 Two states: IDLE, GRANT; state, grant_id, rr_ptr, byte_cnt, idle_cnt are registers.
REQ-015 IDLE: serial_out_valid=0, req_ready=all 0, grant_active=0.
REQ-016 IDLE with any req_valid set: next cycle GRANT, grant_id=first set index searching upward from rr_ptr with wrap NREQ-1->0; byte_cnt=0, idle_cnt=0.
REQ-017 IDLE with no req_valid: stay IDLE, no register changes.
REQ-018 GRANT: serial_out_valid=req_valid[grant_id], serial_out_bits=req_bits slice grant_id, req_ready[grant_id]=serial_out_ready, all other req_ready bits 0; combinational pass-through, zero latency.
REQ-019 Transfer = serial_out_valid & serial_out_ready in GRANT; each transfer increments byte_cnt by 1.
REQ-020 Release on transfer of byte 0x0A (newline); that byte is delivered in the releasing cycle.
REQ-021 Release on the transfer that makes byte_cnt reach MAX_HOLD.
REQ-022 Cycle in GRANT with req_valid[grant_id]=0: idle_cnt increments; idle_cnt reaching IDLE_TIMEOUT releases; any cycle with req_valid[grant_id]=1 (stalled or not) clears idle_cnt to 0.
REQ-023 Release: next state IDLE, rr_ptr=(grant_id+1) mod NREQ, byte_cnt and idle_cnt cleared; exactly one IDLE bubble cycle precedes the next grant.
REQ-024 Multiple release conditions in one cycle yield a single release; no byte is dropped or duplicated.
REQ-025 Backpressure: serial_out_ready=0 holds the byte; no count changes; requester byte must stay stable until transfer.
REQ-026 Non-granted requesters' req_valid changes have no effect during GRANT.
REQ-027 Counters are clog2(256) bits wide; no wrap occurs since release precedes overflow.

Reset
REQ-028 reset=0 asynchronously forces state=IDLE, rr_ptr=0, grant_id=0, byte_cnt=0, idle_cnt=0; outputs serial_out_valid=0, req_ready=0, grant_active=0, serial_out_bits=0.
REQ-029 reset asserted mid-grant abandons the grant immediately; no partial transfer is completed after reset assertion.
REQ-030 First arbitration after reset release starts from requester 0.

Verification (NREQ=4, MAX_HOLD=8, IDLE_TIMEOUT=4)
REQ-031 Req 2 sends "hi\n", ready=1 -> grant at cycle 1, bytes 0x68,0x69,0x0A on cycles 1-3, IDLE cycle 4, rr_ptr=3.
REQ-032 All four valid continuously, each line "a\n" -> grants in order 0,1,2,3,0 with one bubble between grants.
REQ-033 Req 1 streams 20 bytes without 0x0A, req 3 valid -> 8 bytes from req 1, release, then grant_id=3.
REQ-034 Req 0 granted, sends 1 byte then drops valid, req 2 valid -> release after 4 idle cycles, grant_id=2.
REQ-035 Granted req 0 valid, serial_out_ready=0 for 10 cycles -> no timeout release, byte delivered when ready=1.
REQ-036 reset=0 during GRANT with byte pending -> outputs 0 immediately; after release, req 3 alone valid -> grant_id=3, rr search from 0.
